// File: rtl/fetch_width_adapter.sv
// Splits one wide instruction fetch into BEATS narrow fetches and reassembles the
// responses, beat 0 in the least-significant lane. Equal widths collapse to wires.
module fetch_width_adapter #(
    parameter int WIDE_W   = 128,
    parameter int NARROW_W = 32,
    parameter int MAX_OUT  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wide_req,
    input  logic [31:0]         wide_addr,
    output logic                wide_gnt,
    output logic                wide_rvalid,
    output logic [WIDE_W-1:0]   wide_rdata,
    output logic                narrow_req,
    output logic [31:0]         narrow_addr,
    input  logic                narrow_gnt,
    input  logic                narrow_rvalid,
    input  logic [NARROW_W-1:0] narrow_rdata
);
    localparam int BEATS = WIDE_W / NARROW_W;
    localparam int NB    = NARROW_W / 8;
    localparam int WB    = WIDE_W / 8;
    localparam int CW    = $clog2(BEATS + 1);

    generate
        if (WIDE_W == NARROW_W) begin : g_wire
            assign narrow_req  = wide_req;
            assign narrow_addr = wide_addr;
            assign wide_gnt    = narrow_gnt;
            assign wide_rvalid = narrow_rvalid;
            assign wide_rdata  = narrow_rdata;

            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, flush};
        end else begin : g_adapt
            typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

            state_t            state_q, state_d;
            logic [31:0]       base_q, base_d;
            logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
            logic [CW-1:0]     resp_cnt_q, resp_cnt_d;
            logic              drop_q, drop_d;
            logic              wide_rvalid_q, wide_rvalid_d;
            logic [WIDE_W-1:0] wide_rdata_q, wide_rdata_d;
            logic [CW-1:0]     outstanding, out_after;
            logic              issue_fire, resp_fire;

            // Handshake: narrow_req/narrow_addr stay stable until narrow_gnt is seen
            // (only a flush withdraws a pending request); each grant is answered by
            // exactly one in-order narrow_rvalid.
            assign outstanding = issue_cnt_q - resp_cnt_q;
            assign wide_gnt    = wide_req && (state_q == IDLE) && !flush;
            assign narrow_req  = (state_q == ISSUE) && (outstanding < CW'(MAX_OUT))
                                 && !drop_q && !flush;
            assign narrow_addr = base_q + 32'(issue_cnt_q) * 32'(NB);
            assign issue_fire  = narrow_req && narrow_gnt;
            // Responses with nothing outstanding (e.g. stragglers after reset) are dropped.
            assign resp_fire   = narrow_rvalid && (outstanding != '0);
            assign out_after   = outstanding + CW'(issue_fire) - CW'(resp_fire);
            assign wide_rvalid = wide_rvalid_q;
            assign wide_rdata  = wide_rdata_q;

            always_comb begin
                state_d       = state_q;
                base_d        = base_q;
                issue_cnt_d   = issue_cnt_q + CW'(issue_fire);
                resp_cnt_d    = resp_cnt_q + CW'(resp_fire);
                drop_d        = drop_q;
                wide_rvalid_d = 1'b0;
                wide_rdata_d  = wide_rdata_q;

                if (resp_fire && !drop_q) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (resp_cnt_q == CW'(b)) begin
                            wide_rdata_d[b*NARROW_W +: NARROW_W] = narrow_rdata;
                        end
                    end
                end

                case (state_q)
                    IDLE: begin
                        if (wide_gnt) begin
                            base_d      = wide_addr & ~32'(WB - 1);
                            issue_cnt_d = '0;
                            resp_cnt_d  = '0;
                            drop_d      = 1'b0;
                            state_d     = ISSUE;
                        end
                    end
                    ISSUE, DRAIN: begin
                        if (flush) begin
                            drop_d = 1'b1;
                        end
                        // An aborted fetch only waits for its in-flight beats to drain.
                        if (drop_d) begin
                            state_d = (out_after == '0) ? IDLE : DRAIN;
                        end else if (resp_fire && (resp_cnt_q == CW'(BEATS - 1))) begin
                            state_d       = RESP;
                            wide_rvalid_d = 1'b1;
                        end else if (issue_cnt_d == CW'(BEATS)) begin
                            state_d = DRAIN;
                        end
                    end
                    RESP: begin
                        state_d = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q       <= IDLE;
                    base_q        <= '0;
                    issue_cnt_q   <= '0;
                    resp_cnt_q    <= '0;
                    drop_q        <= 1'b0;
                    wide_rvalid_q <= 1'b0;
                    wide_rdata_q  <= '0;
                end else begin
                    state_q       <= state_d;
                    base_q        <= base_d;
                    issue_cnt_q   <= issue_cnt_d;
                    resp_cnt_q    <= resp_cnt_d;
                    drop_q        <= drop_d;
                    wide_rvalid_q <= wide_rvalid_d;
                    wide_rdata_q  <= wide_rdata_d;
                end
            end
        end
    endgenerate

endmodule
